// File: rtl/qed_dup_queue.sv
// SQED duplication queue: issues and stores original instructions, then replays them as QED duplicates.
// Optional build macro QED_NOP_FILTER_EN: NOPs issued in ORIG are not stored for replay.
module qed_dup_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] instruction_in,
  input  logic        exec_dup,
  output logic [31:0] instruction_out,
  output logic        qed_mode,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        dup_done
);

  localparam logic [31:0] NOP = 32'h0000007F;

  typedef enum logic [1:0] {ORIG, DUP, DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push, pop, keep;
  logic [31:0]       out_nxt;
  logic [31:0]       head;

  // Remap registers into x16-x31 and memory offsets into the upper half.
  function automatic logic [31:0] dup_insn(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    case (x[6:0])
      7'h13: begin y[11] = 1'b1; y[19] = 1'b1; end
      7'h33: begin y[11] = 1'b1; y[19] = 1'b1; y[24] = 1'b1; end
      7'h03: if (x[14:12] == 3'b010) begin y[11] = 1'b1; y[30] = 1'b1; end
      7'h23: if (x[14:12] == 3'b010) begin y[24] = 1'b1; y[30] = 1'b1; end
      default: y = x;
    endcase
    return y;
  endfunction

  assign head       = mem[rd_ptr];
  assign fifo_full  = (count == (ADDR_W+1)'(DEPTH));
  assign fifo_empty = (count == '0);

`ifdef QED_NOP_FILTER_EN
  assign keep = (instruction_in[6:0] != 7'h7F);
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ORIG;
      instruction_out <= NOP;
      qed_mode        <= 1'b0;
      dup_done        <= 1'b0;
    end else if (ena) begin
      state           <= state_nxt;
      instruction_out <= out_nxt;
      qed_mode        <= (state_nxt != ORIG);
      dup_done        <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        ORIG:    if (exec_dup) state_nxt = fifo_empty ? DONE : DUP;
        DUP:     if (count <= (ADDR_W+1)'(1)) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    out_nxt = instruction_out;
    if (ena) begin
      case (state)
        ORIG: begin
          if (exec_dup || fifo_full) begin
            out_nxt = NOP;
          end else begin
            out_nxt = instruction_in;
            push    = keep;
          end
        end
        DUP: begin
          pop     = !fifo_empty;
          out_nxt = fifo_empty ? NOP : dup_insn(head);
        end
        default: out_nxt = NOP;
      endcase
    end
  end

  // Queue storage carries data only; pointers and count are control.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instruction_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qed_dup_queue.sv
// Scoreboard bench for qed_dup_queue: directed stimulus pushes expected outputs, a monitor compares.
module tb_qed_dup_queue;

  localparam logic [31:0] NOP   = 32'h0000007F;
  localparam logic [31:0] ADDI  = 32'h00510093;
  localparam logic [31:0] DADDI = 32'h00590893;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [31:0] instruction_in = NOP;
  logic        exec_dup = 1'b0;
  logic [31:0] instruction_out;
  logic        qed_mode, fifo_full, fifo_empty, dup_done;

  typedef struct {
    logic [31:0] out;
    logic        q, d, f, e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  qed_dup_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .instruction_in(instruction_in),
    .exec_dup(exec_dup), .instruction_out(instruction_out), .qed_mode(qed_mode),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .dup_done(dup_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge issued by the driver.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("instruction_out", instruction_out, x.out);
      chk("qed_mode", 32'(qed_mode), 32'(x.q));
      chk("dup_done", 32'(dup_done), 32'(x.d));
      chk("fifo_full", 32'(fifo_full), 32'(x.f));
      chk("fifo_empty", 32'(fifo_empty), 32'(x.e));
    end
  end

  task automatic step(input logic r, input logic en, input logic [31:0] ins, input logic x,
                      input logic [31:0] eo, input logic eq, input logic ed,
                      input logic ef, input logic ee);
    exp_t t;
    rst = r; ena = en; instruction_in = ins; exec_dup = x;
    t.out = eo; t.q = eq; t.d = ed; t.f = ef; t.e = ee;
    sb.push_back(t);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, ADDI, 1'b1, NOP, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] add_i(input int i);
    return {7'b0, 5'((i + 7) % 16), 5'((i + 3) % 16), 3'b000, 5'(i % 16), 7'h33};
  endfunction

  function automatic logic [31:0] dadd_i(input int i);
    return {7'b0, 5'((i + 7) % 16 + 16), 5'((i + 3) % 16 + 16), 3'b000, 5'(i % 16 + 16), 7'h33};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    // Single ADDI, replay
    do_reset();
    step(0, 1, ADDI, 0, ADDI,  0, 0, 0, 0);
    step(0, 1, NOP,  1, NOP,   1, 0, 0, 0);
    step(0, 1, NOP,  0, DADDI, 1, 1, 0, 1);
    step(0, 1, ADDI, 1, NOP,   1, 1, 0, 1);

    // LW / SW ordering
    do_reset();
    step(0, 1, 32'h00802183, 0, 32'h00802183, 0, 0, 0, 0);
    step(0, 1, 32'h00502223, 0, 32'h00502223, 0, 0, 0, 0);
    step(0, 1, NOP,          1, NOP,          1, 0, 0, 0);
    step(0, 1, NOP,          0, 32'h40802983, 1, 0, 0, 0);
    step(0, 1, NOP,          0, 32'h41502223, 1, 1, 0, 1);
    step(0, 1, NOP,          0, NOP,          1, 1, 0, 1);

    // Fill to capacity, overflow drop, replay with an ena=0 hold
    do_reset();
    for (int i = 0; i < 16; i++)
      step(0, 1, add_i(i), 0, add_i(i), 0, 0, (i == 15), 0);
    step(0, 1, add_i(16), 0, NOP, 0, 0, 1, 0);
    step(0, 1, NOP,       1, NOP, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, NOP, 0, dadd_i(i), 1, (i == 15), 0, (i == 15));
      if (i == 4)
        for (int k = 0; k < 3; k++)
          step(0, 0, ADDI, 1, dadd_i(4), 1, 0, 0, 0);
    end
    step(0, 1, NOP, 0, NOP, 1, 1, 0, 1);

    // exec_dup with empty queue goes straight to DONE
    do_reset();
    step(0, 1, ADDI, 1, NOP, 1, 1, 0, 1);
    step(0, 1, ADDI, 0, NOP, 1, 1, 0, 1);

    // Reset mid-replay
    do_reset();
    step(0, 1, ADDI, 0, ADDI,  0, 0, 0, 0);
    step(0, 1, ADDI, 0, ADDI,  0, 0, 0, 0);
    step(0, 1, NOP,  1, NOP,   1, 0, 0, 0);
    step(0, 1, NOP,  0, DADDI, 1, 0, 0, 0);
    step(1, 0, NOP,  0, NOP,   0, 0, 0, 1);
    step(0, 1, ADDI, 0, ADDI,  0, 0, 0, 0);

    // NOP filtering
    do_reset();
`ifdef QED_NOP_FILTER_EN
    step(0, 1, NOP,  0, NOP,   0, 0, 0, 1);
    step(0, 1, ADDI, 0, ADDI,  0, 0, 0, 0);
    step(0, 1, NOP,  0, NOP,   0, 0, 0, 0);
    step(0, 1, NOP,  1, NOP,   1, 0, 0, 0);
    step(0, 1, NOP,  0, DADDI, 1, 1, 0, 1);
    step(0, 1, NOP,  0, NOP,   1, 1, 0, 1);
`else
    step(0, 1, NOP,  0, NOP,   0, 0, 0, 0);
    step(0, 1, ADDI, 0, ADDI,  0, 0, 0, 0);
    step(0, 1, NOP,  0, NOP,   0, 0, 0, 0);
    step(0, 1, NOP,  1, NOP,   1, 0, 0, 0);
    step(0, 1, NOP,  0, NOP,   1, 0, 0, 0);
    step(0, 1, NOP,  0, DADDI, 1, 0, 0, 0);
    step(0, 1, NOP,  0, NOP,   1, 1, 0, 1);
`endif

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qed_dup_queue.md
# qed_dup_queue

Duplication queue feeding the core's fetch port in the SQED harness, directly downstream of the instruction constraint stage. Captures each constrained original instruction, issues it to the core, and stores it. On the symbolic `exec_dup` trigger, replays every stored instruction as its QED duplicate: destination/source registers remapped to x16–x31, memory offsets moved into the upper half. After the replay it issues NOPs until reset, so the consistency checker can compare register halves.

## Interface
Parameters:
- DEPTH, 16, queue capacity in instructions (power of two)
- ADDR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  core fetch advance; state and output update only when 1
- instruction_in  in  32  constrained original instruction (x0–x15 only, NOP = opcode 7'h7F)
- exec_dup  in  1  free/symbolic trigger to switch to duplicate issue
- instruction_out  out  32  registered instruction to core fetch
- qed_mode  out  1  0 = issuing originals, 1 = issuing duplicates or done
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- dup_done  out  1  replay finished; high until reset

## Operation
- States: ORIG, DUP, DONE. Reset state ORIG.
- ORIG, ena=1, exec_dup=0:
  - not full: instruction_out <= instruction_in; enqueue it (subject to Configuration).
  - full: instruction_out <= 32'h0000007F; instruction_in dropped, not enqueued.
- ORIG, ena=1, exec_dup=1: instruction_in ignored; instruction_out <= NOP; next state DUP if queue non-empty, else DONE.
- DUP, ena=1: dequeue head; instruction_out <= dup(head). If this pop empties the queue, next state DONE.
- DONE: instruction_out <= NOP every ena cycle; exec_dup ignored.
- exec_dup is ignored in DUP and DONE.
- dup(x) transform, selected by opcode/funct3:
  - I-type ALU (7'h13): rd |= 16, rs1 |= 16.
  - R-type (7'h33): rd, rs1, rs2 |= 16.
  - LW (7'h03, funct3 010): rd |= 16; instruction[30] = 1; rs1 unchanged (x0).
  - SW (7'h23, funct3 010): rs2 |= 16; instruction[30] = 1; rs1 unchanged.
  - NOP / any other: passed unchanged.
- Queue: circular buffer with ADDR_W-bit read/write pointers wrapping DEPTH-1 -> 0. Count is ADDR_W+1 bits. No push and pop occur in the same cycle, because the states are exclusive.
- ena=0: all state, pointers and outputs hold.

## Timing
- Reset (rst=1 at clk edge, regardless of ena or state): state ORIG, pointers 0, count 0, instruction_out 32'h0000007F, qed_mode 0, fifo_full 0, fifo_empty 1, dup_done 0. Reset mid-replay discards the queue.
- Latency: instruction_in sampled at edge N appears on instruction_out after edge N (one register).
- qed_mode, dup_done: registered; rise on the same edge as the state change into DUP/DONE.
- fifo_full/fifo_empty: derived from the registered count; valid the cycle after the push/pop edge.
- Queue contents are never read in ORIG. Originals issue in arrival order, and duplicates issue in that same order.

## Configuration
- QED_NOP_FILTER_EN defined: ORIG does not enqueue NOPs (opcode 7'h7F). NOPs still pass to instruction_out, and they do not consume capacity.
- Undefined: NOPs are enqueued like any instruction and replayed unchanged in DUP.

## Test plan
- ADDI x1,x2,5 (32'h00510093), ena=1, then exec_dup=1 -> out 32'h00510093, then NOP, then 32'h00590893, then NOP with dup_done=1.
- LW x3,8(x0) (32'h00802183) and SW x5,4(x0) (32'h00502223), then exec_dup -> duplicates 32'h40802983 and 32'h41502223, in that order.
- 16 ADD instructions, then a 17th -> fifo_full=1 after the 16th push, 17th output 32'h0000007F and not replayed. Replay issues exactly 16 duplicates, then DONE.
- exec_dup=1 on the first cycle after reset (queue empty) -> next state DONE directly, dup_done=1, output stays NOP.
- ena=0 for 3 cycles mid-DUP -> instruction_out, count and state hold. Raising rst mid-DUP -> all outputs return to reset values on the next edge.
- NOP, ADDI, NOP, then exec_dup -> with QED_NOP_FILTER_EN, 1 duplicate replayed; without it, 3 entries replayed (NOP, dup ADDI, NOP).
